// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: holds architectural HI/LO, runs fixed-latency
// mult/div operations and raises a pipeline stall while a result is in flight.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        md_use,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        stall
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = ($clog2(MAX_CYC) < 5) ? 5 : $clog2(MAX_CYC);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {IDLE, MULT, DIV} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        hi_q, hi_d, lo_q, lo_d;
  logic [31:0]        pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic               pend_wr_q, pend_wr_d;

  // Even opcodes (mult/div) are signed; the low 64 bits of the product of the
  // sign-extended operands equal the signed product.
  logic        is_signed;
  logic [63:0] ext_a, ext_b, prod;
  assign is_signed = ~op[0];
  assign ext_a     = {{32{is_signed & src_a[31]}}, src_a};
  assign ext_b     = {{32{is_signed & src_b[31]}}, src_b};
  assign prod      = ext_a * ext_b;

  // Divide on magnitudes so -2^31 / -1 falls out as 0x80000000 rem 0 without overflow.
  logic        neg_a, neg_b;
  logic [31:0] mag_a, mag_b, div_b, q_mag, r_mag, quot, rem;
  assign neg_a = is_signed & src_a[31];
  assign neg_b = is_signed & src_b[31];
  assign mag_a = neg_a ? (32'd0 - src_a) : src_a;
  assign mag_b = neg_b ? (32'd0 - src_b) : src_b;
  assign div_b = (mag_b == 32'd0) ? 32'd1 : mag_b;
  assign q_mag = mag_a / div_b;
  assign r_mag = mag_a % div_b;
  assign quot  = (neg_a ^ neg_b) ? (32'd0 - q_mag) : q_mag;
  assign rem   = neg_a ? (32'd0 - r_mag) : r_mag;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              pend_hi_d = prod[63:32];
              pend_lo_d = prod[31:0];
              pend_wr_d = 1'b1;
              cnt_d     = CNT_W'(MULT_CYCLES - 1);
              state_d   = MULT;
            end
            OP_DIV, OP_DIVU: begin
              pend_hi_d = rem;
              pend_lo_d = quot;
              pend_wr_d = (src_b != 32'd0);
              cnt_d     = CNT_W'(DIV_CYCLES - 1);
              state_d   = DIV;
            end
            OP_MTHI: hi_d = src_a;
            OP_MTLO: lo_d = src_a;
            default: ;
          endcase
        end
      end
      MULT, DIV: begin
        if (cnt_q == '0) begin
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      // NOTE: pending registers are cleared too, so a discarded result can never leak out.
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign busy  = (state_q != IDLE);
  assign done  = busy && (cnt_q == '0);
  assign stall = md_use & busy;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: latency, results, stall, ignored starts and reset.
module tb_mdu_ctrl;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  logic        clk = 1'b0;
  logic        reset, start, md_use;
  logic [2:0]  op;
  logic [31:0] src_a, src_b;
  logic [31:0] hi, lo;
  logic        busy, done, stall;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] cur_hi, cur_lo;

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .md_use(md_use), .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall)
  );

  always #5 clk = ~clk;

  // Advance one cycle; inputs are driven and outputs sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; md_use = 1'b1; op = OP_MULT; src_a = '0; src_b = '0;
    step(); step();
    n_checks++; if (hi !== 32'd0)  begin n_fail++; $display("FAIL reset_hi got %h want 0", hi); end
    n_checks++; if (lo !== 32'd0)  begin n_fail++; $display("FAIL reset_lo got %h want 0", lo); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", stall); end
    reset = 1'b1; md_use = 1'b0;
    cur_hi = 32'd0; cur_lo = 32'd0;
    step();
  endtask

  // Issue one mult/div in the current cycle T and check every cycle through T+n+1.
  // If inject_at > 0 a second start is presented during busy cycle inject_at.
  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int n, input logic [31:0] eh,
                        input logic [31:0] el, input int inject_at, input logic [2:0] inject_op);
    start = 1'b1; op = o; src_a = a; src_b = b;
    step();
    start = 1'b0;
    for (int i = 1; i <= n; i++) begin
      if (i == inject_at) begin
        start = 1'b1; op = inject_op; src_a = 32'hDEADBEEF; src_b = 32'h1;
      end
      n_checks++; if (busy !== 1'b1)
        begin n_fail++; $display("FAIL %s busy c%0d got %b want 1", name, i, busy); end
      n_checks++; if (done !== 1'(i == n))
        begin n_fail++; $display("FAIL %s done c%0d got %b want %b", name, i, done, (i == n)); end
      n_checks++; if (stall !== md_use)
        begin n_fail++; $display("FAIL %s stall c%0d got %b want %b", name, i, stall, md_use); end
      n_checks++; if (hi !== cur_hi)
        begin n_fail++; $display("FAIL %s early_hi c%0d got %h want %h", name, i, hi, cur_hi); end
      n_checks++; if (lo !== cur_lo)
        begin n_fail++; $display("FAIL %s early_lo c%0d got %h want %h", name, i, lo, cur_lo); end
      step();
      start = 1'b0;
    end
    n_checks++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL %s busy_after got %b want 0", name, busy); end
    n_checks++; if (done !== 1'b0)  begin n_fail++; $display("FAIL %s done_after got %b want 0", name, done); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL %s stall_after got %b want 0", name, stall); end
    n_checks++; if (hi !== eh) begin n_fail++; $display("FAIL %s hi got %h want %h", name, hi, eh); end
    n_checks++; if (lo !== el) begin n_fail++; $display("FAIL %s lo got %h want %h", name, lo, el); end
    cur_hi = eh; cur_lo = el;
  endtask

  task automatic test_mult();
    run_op("mult", OP_MULT, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA, 2, OP_MTHI);
    run_op("multu", OP_MULTU, 32'hFFFFFFFE, 32'd3, 5, 32'h00000002, 32'hFFFFFFFA, 0, OP_MULT);
  endtask

  task automatic test_div();
    md_use = 1'b1;
    run_op("div_stall", OP_DIV, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, 4, OP_MULT);
    md_use = 1'b0;
    run_op("divu_zero", OP_DIVU, 32'd7, 32'd0, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, OP_MULT);
    run_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000, 0, OP_MULT);
    run_op("div_pos_neg", OP_DIV, 32'd7, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD, 0, OP_MULT);
    run_op("div_neg_neg", OP_DIV, 32'hFFFFFFF9, 32'hFFFFFFFE, 10, 32'hFFFFFFFF, 32'h00000003, 0, OP_MULT);
  endtask

  task automatic test_mthi_mtlo();
    start = 1'b1; op = OP_MTHI; src_a = 32'h12345678; src_b = 32'h0;
    step();
    n_checks++; if (hi !== 32'h12345678) begin n_fail++; $display("FAIL mthi hi got %h want 12345678", hi); end
    n_checks++; if (lo !== cur_lo) begin n_fail++; $display("FAIL mthi lo got %h want %h", lo, cur_lo); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mthi busy got %b want 0", busy); end
    op = OP_MTLO; src_a = 32'h9ABCDEF0;
    step();
    start = 1'b0;
    n_checks++; if (lo !== 32'h9ABCDEF0) begin n_fail++; $display("FAIL mtlo lo got %h want 9abcdef0", lo); end
    n_checks++; if (hi !== 32'h12345678) begin n_fail++; $display("FAIL mtlo hi got %h want 12345678", hi); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mtlo busy got %b want 0", busy); end
    cur_hi = 32'h12345678; cur_lo = 32'h9ABCDEF0;
  endtask

  task automatic test_reserved();
    for (int k = 0; k < 2; k++) begin
      start = 1'b1; op = (k == 0) ? 3'b110 : 3'b111; src_a = 32'h0BADF00D; src_b = 32'd5;
      step();
      start = 1'b0;
      step();
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reserved%0d busy got %b want 0", k, busy); end
      n_checks++; if (hi !== cur_hi) begin n_fail++; $display("FAIL reserved%0d hi got %h want %h", k, hi, cur_hi); end
      n_checks++; if (lo !== cur_lo) begin n_fail++; $display("FAIL reserved%0d lo got %h want %h", k, lo, cur_lo); end
    end
  endtask

  task automatic test_reset_mid_mult();
    md_use = 1'b1;
    start = 1'b1; op = OP_MULT; src_a = 32'hFFFFFFFE; src_b = 32'd3;
    step();
    start = 1'b0;
    step(); step();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rstmid busy_c3 got %b want 1", busy); end
    reset = 1'b0; start = 1'b1; op = OP_MTHI; src_a = 32'h55555555;
    step();
    reset = 1'b1; start = 1'b0;
    n_checks++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL rstmid busy got %b want 0", busy); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rstmid stall got %b want 0", stall); end
    n_checks++; if (hi !== 32'd0)   begin n_fail++; $display("FAIL rstmid hi got %h want 0", hi); end
    n_checks++; if (lo !== 32'd0)   begin n_fail++; $display("FAIL rstmid lo got %h want 0", lo); end
    for (int i = 0; i < 8; i++) begin
      step();
      n_checks++; if (done !== 1'b0 || busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0)
        begin n_fail++; $display("FAIL rstmid_quiet c%0d got done=%b busy=%b hi=%h lo=%h want 0", i, done, busy, hi, lo); end
    end
    md_use = 1'b0;
    cur_hi = 32'd0; cur_lo = 32'd0;
  endtask

  task automatic test_back_to_back();
    run_op("mult_after_rst", OP_MULT, 32'd7, 32'd6, 5, 32'd0, 32'd42, 0, OP_MULT);
    run_op("b2b_divu", OP_DIVU, 32'hFFFFFFFF, 32'd16, 10, 32'h0000000F, 32'h0FFFFFFF, 0, OP_MULT);
    run_op("b2b_multu", OP_MULTU, 32'h80000000, 32'h80000000, 5, 32'h40000000, 32'h00000000, 0, OP_MULT);
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mthi_mtlo();
    test_reserved();
    test_reset_mid_mult();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 The block SHALL have parameter MULT_CYCLES, default 5, meaning the busy cycles for mult/multu.
REQ-002 The block SHALL have parameter DIV_CYCLES, default 10, meaning the busy cycles for div/divu.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-low reset (0 = reset, sampled on the clk rising edge).
REQ-005 The block SHALL have port start  input  1  a one-cycle issue strobe from the E stage.
REQ-006 The block SHALL have port op  input  3  the operation code: 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo; 110 and 111 are reserved.
REQ-007 The block SHALL have ports src_a and src_b  input  32  the E-stage forwarded rs and rt operands.
REQ-008 The block SHALL have port md_use  input  1  set when the E-stage instruction is any mult/div/mfhi/mflo/mthi/mtlo.
REQ-009 The block SHALL have ports hi and lo  output  32  the architectural HI and LO registers.
REQ-010 The block SHALL have port busy  output  1  set while a mult/div is in flight.
REQ-011 The block SHALL have port done  output  1  a one-cycle pulse in the final busy cycle.
REQ-012 The block SHALL have port stall  output  1  a request to freeze the F/D/E stages and bubble M.

Function
REQ-013 The block SHALL implement an FSM with states IDLE, MULT and DIV, plus a down-counter cnt of at least 5 bits.
REQ-014 In IDLE with start=1 and op=mult/multu, the block SHALL compute the 64-bit signed/unsigned product of src_a and src_b into pending registers, load cnt=MULT_CYCLES-1 and enter MULT.
REQ-015 In IDLE with start=1 and op=div/divu, the block SHALL load cnt=DIV_CYCLES-1 and enter DIV.
REQ-016 For div/divu, the block SHALL compute pending LO = quotient and pending HI = remainder, rounding the quotient toward zero; the signed remainder SHALL take the sign of the dividend.
REQ-017 For div with -2^31 / -1, the block SHALL produce LO=0x80000000 and HI=0.
REQ-018 For div/divu with src_b=0, the block SHALL run the full DIV_CYCLES with busy and done behaving normally and SHALL leave HI/LO unchanged at commit.
REQ-019 In MULT/DIV, the block SHALL decrement cnt each cycle.
REQ-020 When cnt==0 in MULT/DIV, the block SHALL pulse done, write the pending values into HI/LO on that edge and return to IDLE.
REQ-021 For a start in cycle T, busy SHALL be 1 in cycles T+1..T+N (N = MULT_CYCLES or DIV_CYCLES), done SHALL be 1 in cycle T+N only, and the new HI/LO SHALL be visible from cycle T+N+1.
REQ-022 For mthi/mtlo in IDLE, the block SHALL write src_a to HI/LO at the next edge with no busy cycle, so the new value is visible from cycle T+1.
REQ-023 A start with a reserved op SHALL have no effect.
REQ-024 The block SHALL drive stall = md_use & busy combinationally; stall SHALL be 0 whenever busy=0.
REQ-025 A start received while busy=1 SHALL be ignored, leaving state, counter and pending values unchanged.
REQ-026 hi and lo SHALL change only on commit, mthi/mtlo or reset; pending values SHALL never be visible before commit.

Reset
REQ-027 On a clk edge with reset=0, the block SHALL clear the state to IDLE, and clear cnt, hi, lo, the pending registers, busy, done and stall to 0; this SHALL hold even mid-MULT/DIV, with the in-flight result discarded.
REQ-028 start SHALL be ignored on any edge where reset=0.
REQ-029 The first start accepted after reset is released SHALL behave per REQ-014..REQ-022.

Verification
REQ-030 The bench SHALL cover signed mult: start, op=000, src_a=0xFFFFFFFE, src_b=3 -> busy 5 cycles, done in the 5th, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-031 The bench SHALL cover multu with the same operands -> hi=0x00000002, lo=0xFFFFFFFA after 5 busy cycles.
REQ-032 The bench SHALL cover div: src_a=-7, src_b=2, op=010 -> 10 busy cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu 7/0 leaves the prior hi/lo unchanged.
REQ-033 The bench SHALL cover md_use=1 held during a div -> stall=1 for all 10 busy cycles and 0 in the cycle after done; a second start mid-busy has no effect.
REQ-034 The bench SHALL cover mthi 0x12345678 followed next cycle by mtlo 0x9ABCDEF0 -> hi/lo update one cycle after each, with busy staying 0.
REQ-035 The bench SHALL cover reset=0 asserted at cycle 3 of a mult -> next cycle busy=0, hi=lo=0, state IDLE, and the product is never committed.
